uart_cmd_parser: RTL



---
 rtl/uart_cmd_parser_pkg.sv | 27 ++
 rtl/uart_cmd_parser_if.sv | 26 ++
 rtl/uart_cmd_parser_timer.sv | 31 +++
 rtl/uart_cmd_parser.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser: command byte
// layout, parser state encoding and the register offsets it addresses.
package uart_cmd_parser_pkg;

    typedef struct packed {
        logic       wr;
        logic [3:0] rsvd;
        logic [2:0] addr;
    } uart_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        READ,
        WAIT_TX,
        SEND
    } uart_parser_state_t;

    localparam logic [7:0] UART_CMD_RSVD_MASK = 8'h78;

    localparam logic [2:0] UART_CR_OFFSET   = 3'd0;
    localparam logic [2:0] UART_SR_OFFSET   = 3'd1;
    localparam logic [2:0] UART_DINL_OFFSET = 3'd2;
    localparam logic [2:0] UART_DINH_OFFSET = 3'd3;
    localparam logic [2:0] UART_DOUT_OFFSET = 3'd4;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bundle between the UART receiver/transmitter/register file and the
// command parser. The parser uses the master view; its environment the slave.
interface uart_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_error;
    logic       tx_busy;
    logic [2:0] rwaddr;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       tx_data_valid;
    logic       cmd_err;

    modport master (
        input  rx_data, rx_data_valid, rx_error, tx_busy,
        output rwaddr, wr_req, wr_data, rd_req, tx_data_valid, cmd_err
    );

    modport slave (
        output rx_data, rx_data_valid, rx_error, tx_busy,
        input  rwaddr, wr_req, wr_data, rd_req, tx_data_valid, cmd_err
    );

endinterface

// File: rtl/uart_cmd_parser_timer.sv
// Inter-byte timer: counts enabled cycles from a clear, saturating at
// TIMEOUT_CYCLES-1 and flagging expiry while it sits there.
module uart_byte_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q;

    // Count enabled cycles, holding at the last value instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-level command decoder: turns received command/data bytes into
// register write/read strobes, sequences the read byte into the transmitter
// and pulses cmd_err on malformed, timed-out or overrun traffic.
// Outputs are registered and computed one cycle ahead so each strobe lines
// up with the state it belongs to (rd_req at +1, tx_data_valid at +3).
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_cmd_parser_if.master     bus
);

    uart_parser_state_t state_q, state_d;
    logic [2:0] rwaddr_q, rwaddr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_req_q, wr_req_d;
    logic       rd_req_q, rd_req_d;
    logic       tx_valid_q, tx_valid_d;
    logic       cmd_err_q, cmd_err_d;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;
    uart_cmd_t  cmd;

    assign cmd          = uart_cmd_t'(bus.rx_data);
    assign timer_enable = (state_q == WAIT_DATA);
    assign timer_clear  = (state_q != WAIT_DATA);

    uart_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State and registered outputs; reset drops any command in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rwaddr_q   <= '0;
            wr_data_q  <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rwaddr_q   <= rwaddr_d;
            wr_data_q  <= wr_data_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Next state and next-cycle strobes from the current state and rx byte.
    always_comb begin
        state_d    = state_q;
        rwaddr_d   = rwaddr_q;
        wr_data_d  = wr_data_q;
        wr_req_d   = 1'b0;
        rd_req_d   = 1'b0;
        tx_valid_d = 1'b0;
        cmd_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_data_valid) begin
                    if (bus.rx_error || (cmd.rsvd != 4'd0)) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd.wr) begin
                        rwaddr_d = cmd.addr;
                        state_d  = WAIT_DATA;
                    end else begin
                        rwaddr_d = cmd.addr;
                        rd_req_d = 1'b1;
                        state_d  = READ;
                    end
                end
            end
            WAIT_DATA: begin
                if (bus.rx_data_valid) begin
                    if (bus.rx_error) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        wr_data_d = bus.rx_data;
                        wr_req_d  = 1'b1;
                    end
                    state_d = IDLE;
                end else if (timer_expired) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            READ: begin
                cmd_err_d = bus.rx_data_valid;
                state_d   = WAIT_TX;
            end
            WAIT_TX: begin
                cmd_err_d = bus.rx_data_valid;
                if (!bus.tx_busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                cmd_err_d = bus.rx_data_valid;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rwaddr        = rwaddr_q;
    assign bus.wr_data       = wr_data_q;
    assign bus.wr_req        = wr_req_q;
    assign bus.rd_req        = rd_req_q;
    assign bus.tx_data_valid = tx_valid_q;
    assign bus.cmd_err       = cmd_err_q;

endmodule
